challenge_responder: RTL and testbench
======================================

// Module: challenge_responder
// PURPOSE
//  OBC-side end of the challenge/response health check. Accepts a 4-bit question
//  from the error-checking state machine, computes the answer after a fixed
//  delay, and holds it until acknowledged. Monitors ack timeouts and question
//  overruns. Halts permanently on a shutdown command from the checker.
// PARAMETERS
//  RESPONSE_DELAY  2   cycles from question accept to answer_valid (>=1)
//  ACK_TIMEOUT     16  cycles answer_valid may stay high without ack (>=1)
//  CNT_WIDTH       8   width of answer_count
// PORTS
//  clk            in   1          single clock, all logic on rising edge
//  reset          in   1          asynchronous, active-low; low = reset
//  question       in   4          challenge word, sampled with question_valid
//  question_valid in   1          one-cycle question strobe from checker
//  answer_ack     in   1          checker has consumed answer
//  shutdown       in   1          level; checker orders this OBC offline
//  answer         out  4          computed response, stable while answer_valid
//  answer_valid   out  1          answer presented, waiting for ack
//  busy           out  1          high in COMPUTE or RESPOND
//  overrun        out  1          1-cycle pulse: question dropped while busy
//  timeout        out  1          1-cycle pulse: ack not received in time
//  halted         out  1          high in HALTED
//  answer_count   out  CNT_WIDTH  acknowledged answers, saturating
// BEHAVIOUR
//  Reset (reset low, async): state IDLE; all outputs 0; counters 0.
//  Answer function (from latched q): a[0]=~q[0]; a[1]=q[0]^q[1];
//   a[2]=q[1]^q[2]; a[3]=q[2]^q[3]. answer is 0 outside RESPOND.
//  States: IDLE, COMPUTE, RESPOND, HALTED.
//  IDLE: question_valid=1 at edge k -> latch question, load delay counter with
//   RESPONSE_DELAY-1, go COMPUTE. answer_ack is ignored.
//  COMPUTE: delay counter==0 at edge -> RESPOND, else decrement.
//   answer_valid is first high after edge k+RESPONSE_DELAY.
//  RESPOND: answer_valid=1, answer held. Wait counter increments each cycle.
//   answer_ack=1 at edge -> IDLE; answer_count+1 (holds at all-ones).
//   If ACK_TIMEOUT cycles pass with no ack -> IDLE; timeout pulses 1 cycle;
//   count is unchanged.
//   If ack arrives in the same cycle the timeout expires, ack wins and timeout
//   does not pulse.
//  question_valid in COMPUTE/RESPOND: ignored; overrun pulses next cycle; the
//   latched question is unchanged.
//  question_valid and ack in the same RESPOND cycle: ack is taken, the question
//   is dropped, and overrun pulses.
//  shutdown=1 at any edge, in any state -> HALTED. It has priority over all
//   other events. answer_valid and busy drop next cycle. HALTED is exited only
//   by reset. In HALTED all inputs are ignored and overrun does not pulse.
//  Reset mid-operation: immediate return to IDLE; the in-flight question is
//   lost and answer_count clears.
// TESTING
//  1 q=4'b0110 strobe, ack 1 cycle after valid -> answer=4'b1011;
//    valid at k+2; answer_count=1.
//  2 q=4'h0 -> answer 4'b0001; q=4'hF -> answer 4'b0000.
//  3 No ack (ACK_TIMEOUT=16) -> answer_valid high 16 cycles, timeout pulse,
//    IDLE, count 0. Ack on the 16th cycle -> no timeout, count increments.
//  4 Second question_valid during COMPUTE -> overrun pulse; answer still from
//    the first question.
//  5 shutdown during RESPOND -> answer_valid low next cycle, halted=1; later
//    questions ignored with no overrun; reset low -> IDLE, all outputs 0.
//  6 CNT_WIDTH=2, five acked exchanges -> answer_count saturates at 2'b11.
//    Reset during COMPUTE -> no answer_valid is produced.

Source files
------------

// File: rtl/challenge_responder.sv
// -----------------------------------------------------------------------------
// challenge_responder
//
// OBC-side end of the challenge/response health check. A 4-bit question from
// the checker is latched, the answer is presented a fixed number of cycles
// later and held until acknowledged. Missing acks are reported as a timeout and
// questions arriving while busy are reported as an overrun. A shutdown command
// parks the block in HALTED until the next reset.
//
// Ports
//   clk            in   1          rising-edge clock
//   reset          in   1          asynchronous, active-low reset
//   question       in   4          challenge word, sampled with question_valid
//   question_valid in   1          one-cycle question strobe
//   answer_ack     in   1          checker has consumed the answer
//   shutdown       in   1          level; forces HALTED
//   answer         out  4          response, 0 unless answer_valid
//   answer_valid   out  1          answer presented, waiting for ack
//   busy           out  1          high in COMPUTE or RESPOND
//   overrun        out  1          1-cycle pulse: question dropped while busy
//   timeout        out  1          1-cycle pulse: ack did not arrive in time
//   halted         out  1          high in HALTED
//   answer_count   out  CNT_WIDTH  acknowledged answers, saturating
// -----------------------------------------------------------------------------
module challenge_responder #(
  parameter int RESPONSE_DELAY = 2,   // cycles from accept to answer_valid (>=1)
  parameter int ACK_TIMEOUT    = 16,  // cycles answer_valid may wait for ack (>=1)
  parameter int CNT_WIDTH      = 8    // width of answer_count
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           question,
  input  logic                 question_valid,
  input  logic                 answer_ack,
  input  logic                 shutdown,
  output logic [3:0]           answer,
  output logic                 answer_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] answer_count
);

  // Counters are sized to hold their largest load value even when that value
  // is a power of two.
  localparam int DLY_W  = $clog2(RESPONSE_DELAY + 1);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(RESPONSE_DELAY - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_RESPOND,
    S_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             q_q, q_d;           // latched question
  logic [DLY_W-1:0]       dly_q, dly_d;       // remaining COMPUTE cycles
  logic [WAIT_W-1:0]      wait_q, wait_d;     // cycles spent in RESPOND
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;       // acknowledged answers
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned and infers a latch.
    state_d   = state_q;
    q_d       = q_q;
    dly_d     = dly_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;

    if (state_q == S_HALTED) begin
      // Only reset leaves HALTED; every input is ignored here.
      state_d = S_HALTED;
    end else if (shutdown) begin
      // Shutdown outranks acks, questions and timeouts in every state.
      state_d = S_HALTED;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (question_valid) begin
            q_d     = question;
            dly_d   = DLY_LOAD;
            state_d = S_COMPUTE;
          end
        end

        S_COMPUTE: begin
          overrun_d = question_valid;
          if (dly_q == '0) begin
            wait_d  = '0;
            state_d = S_RESPOND;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end

        S_RESPOND: begin
          overrun_d = question_valid;
          if (answer_ack) begin
            // An ack on the expiry cycle still counts: ack is checked first.
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            state_d = S_IDLE;
          end else if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      dly_q     <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      q_q       <= q_d;
      dly_q     <= dly_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    answer_valid = (state_q == S_RESPOND);
    busy         = (state_q == S_COMPUTE) || (state_q == S_RESPOND);
    halted       = (state_q == S_HALTED);
    answer       = 4'b0000;
    if (answer_valid) begin
      answer[0] = ~q_q[0];
      answer[1] = q_q[0] ^ q_q[1];
      answer[2] = q_q[1] ^ q_q[2];
      answer[3] = q_q[2] ^ q_q[3];
    end
  end

  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign answer_count = cnt_q;

endmodule

// File: tb/tb_challenge_responder.sv
// -----------------------------------------------------------------------------
// tb_challenge_responder
//
// Two instances share the same stimulus: one with an 8-bit answer counter and
// one with a 2-bit counter, so saturation is observed alongside normal traffic.
// The reference model tracks the exchange with absolute edge numbers: the edge
// at which the answer appears and the edge at which the ack window closes.
// -----------------------------------------------------------------------------
module tb_challenge_responder;

  localparam int RD = 2;
  localparam int AT = 16;

  logic       clk;
  logic       reset;
  logic [3:0] question;
  logic       question_valid;
  logic       answer_ack;
  logic       shutdown;

  logic [3:0] answer_a,  answer_b;
  logic       valid_a,   valid_b;
  logic       busy_a,    busy_b;
  logic       overrun_a, overrun_b;
  logic       timeout_a, timeout_b;
  logic       halted_a,  halted_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  challenge_responder #(.RESPONSE_DELAY(RD), .ACK_TIMEOUT(AT), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .question(question), .question_valid(question_valid),
    .answer_ack(answer_ack), .shutdown(shutdown), .answer(answer_a),
    .answer_valid(valid_a), .busy(busy_a), .overrun(overrun_a), .timeout(timeout_a),
    .halted(halted_a), .answer_count(count_a)
  );

  challenge_responder #(.RESPONSE_DELAY(RD), .ACK_TIMEOUT(AT), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .question(question), .question_valid(question_valid),
    .answer_ack(answer_ack), .shutdown(shutdown), .answer(answer_b),
    .answer_valid(valid_b), .busy(busy_b), .overrun(overrun_b), .timeout(timeout_b),
    .halted(halted_b), .answer_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         edge_n;
  bit         m_pending;   // a question is in flight (computing or answered)
  bit         m_halted;
  bit         m_ov;
  bit         m_to;
  logic [3:0] m_q;
  int         m_ready;     // edge after which the answer is valid
  int         m_count;     // unbounded count of acknowledged answers

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_halted  = 1'b0;
    m_ov      = 1'b0;
    m_to      = 1'b0;
    m_q       = 4'h0;
    m_ready   = 0;
    m_count   = 0;
  endtask

  // Applies the rules to the inputs sampled at the edge just taken.
  task automatic model_edge();
    edge_n++;
    m_ov = 1'b0;
    m_to = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (m_halted) begin
      // nothing leaves HALTED except reset
    end else if (shutdown) begin
      m_halted  = 1'b1;
      m_pending = 1'b0;
    end else if (!m_pending) begin
      if (question_valid) begin
        m_pending = 1'b1;
        m_q       = question;
        m_ready   = edge_n + RD;
      end
    end else begin
      m_ov = question_valid;
      if (edge_n > m_ready && answer_ack) begin
        m_count++;
        m_pending = 1'b0;
      end else if (edge_n == m_ready + AT) begin
        m_to      = 1'b1;
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    logic       e_valid;
    logic [3:0] e_ans;
    logic [7:0] e_cnt_a;
    logic [1:0] e_cnt_b;
    e_valid = m_pending && (edge_n >= m_ready);
    // a[0] = ~q[0], a[i] = q[i] ^ q[i-1]
    e_ans   = e_valid ? (m_q ^ {m_q[2:0], 1'b1}) : 4'h0;
    e_cnt_a = (m_count > 255) ? 8'hFF : 8'(m_count);
    e_cnt_b = (m_count > 3)   ? 2'b11 : 2'(m_count);
    check({ph, " answer_a"},  {4'd0, answer_a},  {4'd0, e_ans});
    check({ph, " answer_b"},  {4'd0, answer_b},  {4'd0, e_ans});
    check({ph, " valid_a"},   {7'd0, valid_a},   {7'd0, e_valid});
    check({ph, " valid_b"},   {7'd0, valid_b},   {7'd0, e_valid});
    check({ph, " busy_a"},    {7'd0, busy_a},    {7'd0, m_pending});
    check({ph, " busy_b"},    {7'd0, busy_b},    {7'd0, m_pending});
    check({ph, " overrun_a"}, {7'd0, overrun_a}, {7'd0, m_ov});
    check({ph, " overrun_b"}, {7'd0, overrun_b}, {7'd0, m_ov});
    check({ph, " timeout_a"}, {7'd0, timeout_a}, {7'd0, m_to});
    check({ph, " timeout_b"}, {7'd0, timeout_b}, {7'd0, m_to});
    check({ph, " halted_a"},  {7'd0, halted_a},  {7'd0, m_halted});
    check({ph, " halted_b"},  {7'd0, halted_b},  {7'd0, m_halted});
    check({ph, " count_a"},   count_a,           e_cnt_a);
    check({ph, " count_b"},   {6'd0, count_b},   {6'd0, e_cnt_b});
  endtask

  // One clock: drive inputs, take the edge, update the model, compare at +1.
  task automatic step(input string ph, input logic [3:0] q, input logic qv,
                      input logic ack, input logic sd);
    question       = q;
    question_valid = qv;
    answer_ack     = ack;
    shutdown       = sd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 4'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks the asynchronous clear.
  task automatic apply_reset(input string ph);
    question_valid = 1'b0;
    answer_ack     = 1'b0;
    shutdown       = 1'b0;
    reset          = 1'b0;
    model_reset();
    #2;
    compare_all(ph);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    edge_n         = 0;
    reset          = 1'b0;
    question       = 4'h0;
    question_valid = 1'b0;
    answer_ack     = 1'b0;
    shutdown       = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: q=0110, answer 1011 two cycles after accept, ack right after.
    step("t1", 4'b0110, 1'b1, 1'b0, 1'b0);
    step("t1", 4'h0, 1'b0, 1'b0, 1'b0);
    check("t1 valid_early", {7'd0, valid_a}, 8'd0);
    step("t1", 4'h0, 1'b0, 1'b0, 1'b0);
    check("t1 valid_at_k2", {7'd0, valid_a}, 8'd1);
    check("t1 answer_const", {4'd0, answer_a}, 8'b0000_1011);
    step("t1", 4'h0, 1'b0, 1'b1, 1'b0);
    check("t1 count_const", count_a, 8'd1);

    // 2: q=0 -> 0001, q=F -> 0000.
    step("t2", 4'h0, 1'b1, 1'b0, 1'b0);
    idle("t2", 2);
    check("t2 answer_q0", {4'd0, answer_a}, 8'b0000_0001);
    step("t2", 4'h0, 1'b0, 1'b1, 1'b0);
    step("t2", 4'hF, 1'b1, 1'b0, 1'b0);
    idle("t2", 2);
    check("t2 valid_qf", {7'd0, valid_a}, 8'd1);
    check("t2 answer_qf", {4'd0, answer_a}, 8'b0000_0000);
    step("t2", 4'h0, 1'b0, 1'b1, 1'b0);

    // 3: no ack -> 16 valid cycles then timeout; ack on the 16th cycle wins.
    step("t3", 4'h5, 1'b1, 1'b0, 1'b0);
    idle("t3", RD + AT - 1);
    check("t3 still_valid", {7'd0, valid_a}, 8'd1);
    idle("t3", 1);
    check("t3 timeout_const", {7'd0, timeout_a}, 8'd1);
    check("t3 count_const", count_a, 8'd3);
    step("t3", 4'hA, 1'b1, 1'b0, 1'b0);
    idle("t3", RD + AT - 1);
    step("t3", 4'h0, 1'b0, 1'b1, 1'b0);
    check("t3 ack_wins_to", {7'd0, timeout_a}, 8'd0);
    check("t3 ack_wins_cnt", count_a, 8'd4);

    // 4: second strobe during COMPUTE -> overrun, answer from the first question.
    step("t4", 4'b0011, 1'b1, 1'b0, 1'b0);
    step("t4", 4'b1100, 1'b1, 1'b0, 1'b0);
    check("t4 overrun_const", {7'd0, overrun_a}, 8'd1);
    step("t4", 4'h0, 1'b0, 1'b0, 1'b0);
    check("t4 answer_first", {4'd0, answer_a}, 8'b0000_0100);
    // Question and ack together in RESPOND: ack taken, question dropped.
    step("t4", 4'h9, 1'b1, 1'b1, 1'b0);
    check("t4 qv_ack_ovr", {7'd0, overrun_a}, 8'd1);
    idle("t4", 3);

    // 5: shutdown during RESPOND, later inputs ignored, reset recovers.
    step("t5", 4'h7, 1'b1, 1'b0, 1'b0);
    idle("t5", 2);
    step("t5", 4'h0, 1'b0, 1'b0, 1'b1);
    check("t5 halted_const", {7'd0, halted_a}, 8'd1);
    step("t5", 4'h3, 1'b1, 1'b1, 1'b0);
    step("t5", 4'h4, 1'b1, 1'b0, 1'b0);
    check("t5 no_overrun", {7'd0, overrun_a}, 8'd0);
    apply_reset("t5 reset");
    idle("t5", 2);

    // 6: five acked exchanges saturate the 2-bit counter; reset in COMPUTE.
    for (int n = 0; n < 5; n++) begin
      step("t6", 4'($urandom), 1'b1, 1'b0, 1'b0);
      idle("t6", RD);
      step("t6", 4'h0, 1'b0, 1'b1, 1'b0);
    end
    check("t6 sat_b", {6'd0, count_b}, 8'd3);
    check("t6 cnt_a", count_a, 8'd5);
    step("t6", 4'hE, 1'b1, 1'b0, 1'b0);
    apply_reset("t6 reset");
    idle("t6", RD + 2);
    check("t6 no_valid", {7'd0, valid_b}, 8'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset("rnd reset");
      end else begin
        step("rnd", 4'($urandom),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
